proj_trigger_gen: RTL
=====================

PROJ_TRIGGER_GEN -- requirements
Module: proj_trigger_gen

Interface
REQ-001 Parameter NCH, default 16: number of coax trigger inputs.
REQ-002 Parameter NROW, default 4: number of rows; NCH SHALL be divisible by NROW, and row r holds channels r*NCH/NROW .. (r+1)*NCH/NROW-1.
REQ-003 Parameter NTRIG, default 8: number of trigger units; unit k drives coax_out[2k] and coax_out[2k+1].
REQ-004 Parameter ROLL_LOG2, default 20: rolling-trigger period exponent.
REQ-005 clk_adc  in  1  sole clock; all logic on its rising edge.
REQ-006 nrst  in  1  reset, asynchronous, active-low.
REQ-007 coax_in  in  NCH  trigger inputs, inverted, so a low level is a hit.
REQ-008 coax_out  out  2*NTRIG  trigger outputs.
REQ-009 coincidence_time  in  8  input stretch length, in cycles.
REQ-010 dead_time  in  8  per-unit dead time, in cycles.
REQ-011 out_width  in  8  output pulse length, in cycles.
REQ-012 trig_mode  in  2*NTRIG  per-unit mode: 0 off, 1 total, 2 row, 3 single-row.
REQ-013 trig_thr  in  5*NTRIG  per-unit threshold.
REQ-014 randnum, prescale  in  32 each  prescale comparison operands.
REQ-015 dorolling  in  1  rolling-trigger enable.
REQ-016 ext_trig_out  out  1  rolling-trigger output.
REQ-017 resethist  in  1  synchronous clear of all counters.
REQ-018 hist_sel  in  8  counter readout index.
REQ-019 hist_out  out  32  selected counter value.

Function
REQ-020 Stage 1: coaxinreg <= ~coax_in; pass_prescale <= (randnum <= prescale_q); prescale_q <= prescale.
REQ-021 Stage 2, per channel:
- coaxinreg high: Tin <= coincidence_time.
- otherwise: Tin decrements toward 0.
- A channel is active while Tin != 0.
REQ-022 Stage 3: Nrow[r] <= number of active channels in row r; Ntot <= sum over all rows; Nact <= number of rows with Nrow != 0.
- Count widths SHALL hold NCH without overflow.
REQ-023 Stage 4, unit k is eligible when dead counter D[k]==0 and its condition holds:
- mode 1: Ntot >= thr.
- mode 2: any Nrow >= thr.
- mode 3: any Nrow >= thr AND Nact == 1.
- mode 0: never.
- thr==0 with modes 1-3: the condition is always true.
REQ-024 When unit k is eligible:
- D[k] <= dead_time, regardless of prescale.
- If pass_prescale: T[k] <= out_width.
- When D[k] != 0: D[k] decrements.
REQ-025 coax_out[2k] and coax_out[2k+1] SHALL be registered as (T[k] != 0), and T[k] SHALL decrement while nonzero.
REQ-026 Latency: a hit sampled at edge N SHALL drive coax_out high from edge N+4 for exactly out_width cycles.
REQ-027 Edge cases:
- out_width=0: no output pulse.
- coincidence_time=0: no channel ever becomes active.
- dead_time=0: the unit may refire every cycle, and T reloads to out_width on each refire.
REQ-028 Rolling trigger:
- A free counter counts up to 2^ROLL_LOG2, then restarts at 0.
- At the wrap, if dorolling: ext_trig_out is high for 4 cycles.

Reset
REQ-029 nrst low SHALL asynchronously clear to 0:
- all Tin, T, and D counters;
- pipeline registers, prescale_q, and the rolling counter;
- coax_out, ext_trig_out, hist_out, and all histogram counters.
REQ-030 Operation SHALL resume at the first edge after release; a reset in mid-pulse SHALL truncate the output pulse.

Configuration
REQ-031 Macro PROJ_TRIGGER_HIST_EN present:
- Per-channel hit counters hin[j] increment on each cycle with coaxinreg[j] high.
- Per-unit fired counters hf[k] increment on each prescale-passed fire.
- All counters are 32 bit and saturate at 0xFFFFFFFF.
- resethist clears all counters and takes priority over increment.
REQ-032 With the macro present, hist_out <= a registered value, with 1 cycle latency:
- hin[hist_sel] for hist_sel < NCH;
- hf[hist_sel-NCH] for NCH <= hist_sel < NCH+NTRIG;
- 0 otherwise.
REQ-033 Macro absent: no counters are built, and hist_out SHALL be constant 0.

Verification
REQ-034 Defaults; unit0 mode 1, thr 2; coincidence_time=5, out_width=16, dead_time=40, prescale=0xFFFFFFFF; coax_in[0] and coax_in[5] low for 1 cycle at the same edge N -> coax_out[1:0] high for edges N+4..N+19; no refire before D expires.
REQ-035 Unit1 mode 2, thr 2; hits on channels 0 and 4 (different rows) -> no fire; hits on channels 0 and 1 -> coax_out[3:2] pulse of 16 cycles.
REQ-036 Unit2 mode 3, thr 2; hits on 0, 1 and 8 -> no fire; hits on 0 and 1 only -> fire.
REQ-037 prescale=0, randnum=5; unit0 condition met -> coax_out stays 0, D loads 40, hf[0] unchanged.
REQ-038 HIST_EN; coax_in[3] low for 7 cycles; hist_sel=3 -> hist_out=7; resethist pulse -> hist_out=0; hist_sel=200 -> 0.
REQ-039 ROLL_LOG2=4, dorolling=1 -> ext_trig_out high for 4 cycles every 17 cycles; nrst pulsed low mid-pulse -> all outputs 0 immediately.

Source files
------------

// File: rtl/proj_trigger_gen.sv
// Coax trigger generator: input stretch, row/total multiplicity, per-unit trigger with dead time and prescale, rolling trigger.
// Optional per-channel and per-unit counters are enabled with PROJ_TRIGGER_HIST_EN.
module proj_trigger_gen #(
    parameter int unsigned NCH       = 16,
    parameter int unsigned NROW      = 4,
    parameter int unsigned NTRIG     = 8,
    parameter int unsigned ROLL_LOG2 = 20
) (
    input  logic                 clk_adc,
    input  logic                 nrst,
    input  logic [NCH-1:0]       coax_in,
    output logic [2*NTRIG-1:0]   coax_out,
    input  logic [7:0]           coincidence_time,
    input  logic [7:0]           dead_time,
    input  logic [7:0]           out_width,
    input  logic [2*NTRIG-1:0]   trig_mode,
    input  logic [5*NTRIG-1:0]   trig_thr,
    input  logic [31:0]          randnum,
    input  logic [31:0]          prescale,
    input  logic                 dorolling,
    output logic                 ext_trig_out,
    input  logic                 resethist,
    input  logic [7:0]           hist_sel,
    output logic [31:0]          hist_out
);

    localparam int unsigned CPR  = NCH / NROW;
    localparam int unsigned CW   = $clog2(NCH + 1);
    localparam int unsigned THW  = 5;
    localparam int unsigned CMPW = (CW > THW) ? CW : THW;
    localparam int unsigned RW   = ROLL_LOG2 + 1;
    localparam logic [RW-1:0] ROLL_MAX = {1'b1, {ROLL_LOG2{1'b0}}};

    logic [NCH-1:0]     coaxinreg_q, coaxinreg_d;
    logic               pass_prescale_q, pass_prescale_d;
    logic [31:0]        prescale_q, prescale_d;
    logic [7:0]         tin_q [NCH];
    logic [7:0]         tin_d [NCH];
    logic [CW-1:0]      nrow_q [NROW];
    logic [CW-1:0]      nrow_d [NROW];
    logic [CW-1:0]      ntot_q, ntot_d;
    logic [CW-1:0]      nact_q, nact_d;
    logic [7:0]         d_q [NTRIG];
    logic [7:0]         d_d [NTRIG];
    logic [7:0]         t_q [NTRIG];
    logic [7:0]         t_d [NTRIG];
    logic [2*NTRIG-1:0] coax_out_q, coax_out_d;
    logic [RW-1:0]      roll_q, roll_d;
    logic [2:0]         ext_cnt_q, ext_cnt_d;
    logic               ext_trig_out_q, ext_trig_out_d;

    logic [NTRIG-1:0]   fire_c;
    logic [1:0]         mode;
    logic [THW-1:0]     thr;
    logic               row_hit;
    logic               cond;
    logic               elig;
    logic               wrap;

    // Stages 1-3: input capture, stretch, multiplicity counts
    always_comb begin
        coaxinreg_d     = ~coax_in;
        prescale_d      = prescale;
        pass_prescale_d = (randnum <= prescale_q);
        ntot_d          = '0;
        nact_d          = '0;
        for (int unsigned j = 0; j < NCH; j++) begin
            if (coaxinreg_q[j])
                tin_d[j] = coincidence_time;
            else if (tin_q[j] != 8'd0)
                tin_d[j] = tin_q[j] - 8'd1;
            else
                tin_d[j] = 8'd0;
        end
        for (int unsigned r = 0; r < NROW; r++) begin
            nrow_d[r] = '0;
            for (int unsigned c = 0; c < CPR; c++) begin
                if (tin_q[r*CPR + c] != 8'd0)
                    nrow_d[r] = nrow_d[r] + CW'(1);
            end
            ntot_d = ntot_d + nrow_d[r];
            if (nrow_d[r] != '0)
                nact_d = nact_d + CW'(1);
        end
    end

    // Stage 4: per-unit trigger decision, dead time and output width
    always_comb begin
        mode       = 2'd0;
        thr        = '0;
        row_hit    = 1'b0;
        cond       = 1'b0;
        elig       = 1'b0;
        fire_c     = '0;
        coax_out_d = '0;
        for (int unsigned k = 0; k < NTRIG; k++) begin
            mode    = trig_mode[2*k +: 2];
            thr     = trig_thr[THW*k +: THW];
            row_hit = 1'b0;
            for (int unsigned r = 0; r < NROW; r++) begin
                if (CMPW'(nrow_q[r]) >= CMPW'(thr))
                    row_hit = 1'b1;
            end
            case (mode)
                2'd1:    cond = (CMPW'(ntot_q) >= CMPW'(thr));
                2'd2:    cond = row_hit;
                2'd3:    cond = row_hit && (nact_q == CW'(1));
                default: cond = 1'b0;
            endcase
            if ((mode != 2'd0) && (thr == '0))
                cond = 1'b1;
            elig      = (d_q[k] == 8'd0) && cond;
            fire_c[k] = elig && pass_prescale_q;
            if (elig)
                d_d[k] = dead_time;
            else if (d_q[k] != 8'd0)
                d_d[k] = d_q[k] - 8'd1;
            else
                d_d[k] = 8'd0;
            if (fire_c[k])
                t_d[k] = out_width;
            else if (t_q[k] != 8'd0)
                t_d[k] = t_q[k] - 8'd1;
            else
                t_d[k] = 8'd0;
            coax_out_d[2*k]     = (t_q[k] != 8'd0);
            coax_out_d[2*k + 1] = (t_q[k] != 8'd0);
        end
    end

    // Rolling trigger: period 2^ROLL_LOG2 + 1, 4-cycle pulse at the wrap
    always_comb begin
        wrap   = (roll_q == ROLL_MAX);
        roll_d = wrap ? '0 : roll_q + RW'(1);
        if (wrap && dorolling)
            ext_cnt_d = 3'd4;
        else if (ext_cnt_q != 3'd0)
            ext_cnt_d = ext_cnt_q - 3'd1;
        else
            ext_cnt_d = 3'd0;
        ext_trig_out_d = (ext_cnt_d != 3'd0);
    end

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            coaxinreg_q     <= '0;
            pass_prescale_q <= 1'b0;
            prescale_q      <= '0;
            for (int unsigned j = 0; j < NCH; j++) tin_q[j] <= '0;
            for (int unsigned r = 0; r < NROW; r++) nrow_q[r] <= '0;
            ntot_q          <= '0;
            nact_q          <= '0;
            for (int unsigned k = 0; k < NTRIG; k++) begin
                d_q[k] <= '0;
                t_q[k] <= '0;
            end
            coax_out_q      <= '0;
            roll_q          <= '0;
            ext_cnt_q       <= '0;
            ext_trig_out_q  <= 1'b0;
        end else begin
            coaxinreg_q     <= coaxinreg_d;
            pass_prescale_q <= pass_prescale_d;
            prescale_q      <= prescale_d;
            for (int unsigned j = 0; j < NCH; j++) tin_q[j] <= tin_d[j];
            for (int unsigned r = 0; r < NROW; r++) nrow_q[r] <= nrow_d[r];
            ntot_q          <= ntot_d;
            nact_q          <= nact_d;
            for (int unsigned k = 0; k < NTRIG; k++) begin
                d_q[k] <= d_d[k];
                t_q[k] <= t_d[k];
            end
            coax_out_q      <= coax_out_d;
            roll_q          <= roll_d;
            ext_cnt_q       <= ext_cnt_d;
            ext_trig_out_q  <= ext_trig_out_d;
        end
    end

    assign coax_out     = coax_out_q;
    assign ext_trig_out = ext_trig_out_q;

`ifdef PROJ_TRIGGER_HIST_EN
    logic [31:0] hin_q [NCH];
    logic [31:0] hin_d [NCH];
    logic [31:0] hf_q [NTRIG];
    logic [31:0] hf_d [NTRIG];
    logic [31:0] hist_out_q, hist_out_d;

    // Saturating counters; resethist wins over increment
    always_comb begin
        hist_out_d = '0;
        for (int unsigned j = 0; j < NCH; j++) begin
            if (resethist)
                hin_d[j] = '0;
            else if (coaxinreg_q[j] && (hin_q[j] != 32'hFFFF_FFFF))
                hin_d[j] = hin_q[j] + 32'd1;
            else
                hin_d[j] = hin_q[j];
            if (32'(hist_sel) == j)
                hist_out_d = hin_q[j];
        end
        for (int unsigned k = 0; k < NTRIG; k++) begin
            if (resethist)
                hf_d[k] = '0;
            else if (fire_c[k] && (hf_q[k] != 32'hFFFF_FFFF))
                hf_d[k] = hf_q[k] + 32'd1;
            else
                hf_d[k] = hf_q[k];
            if (32'(hist_sel) == NCH + k)
                hist_out_d = hf_q[k];
        end
    end

    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned j = 0; j < NCH; j++) hin_q[j] <= '0;
            for (int unsigned k = 0; k < NTRIG; k++) hf_q[k] <= '0;
            hist_out_q <= '0;
        end else begin
            for (int unsigned j = 0; j < NCH; j++) hin_q[j] <= hin_d[j];
            for (int unsigned k = 0; k < NTRIG; k++) hf_q[k] <= hf_d[k];
            hist_out_q <= hist_out_d;
        end
    end

    assign hist_out = hist_out_q;
`else
    logic unused_hist;
    assign unused_hist = ^{resethist, hist_sel};
    assign hist_out    = 32'd0;
`endif

endmodule
